axi_write_master: RTL and testbench
===================================

// Module: axi_write_master
// PURPOSE
// Initiator side of the AXI3 write path: accepts a burst request from a local device, issues
// it on the AW channel, streams the device's data beats on W, then collects the B response.
// Sits between a DMA/engine-style requester and any write slave on the interconnect.
// One burst in flight at a time; no outstanding-transaction reordering.
// PARAMETERS
// BUSWIDTH  32  data width in bits (multiple of 8); WSTRB width is BUSWIDTH/8
// IDWIDTH   2   transaction ID width for AWID/WID/BID
// PORTS
// ACLK         in   1           clock; all logic on rising edge
// ARESETn      in   1           synchronous, active-low reset
// start        in   1           request pulse; sampled only in IDLE
// start_addr   in   32          burst start address
// start_len    in   4           beats-1 (0..15)
// start_size   in   3           bytes/beat = 2**start_size
// start_burst  in   2           00 FIXED, 01 INCR, 10 WRAP (passed through)
// start_id     in   IDWIDTH     transaction ID
// busy         out  1           high whenever state != IDLE
// wdata_in     in   BUSWIDTH    device beat data
// wstrb_in     in   BUSWIDTH/8  device beat strobes
// data_valid   in   1           device beat valid
// data_ready   out  1           beat accepted when data_valid & data_ready
// done         out  1           one-cycle pulse at burst completion
// resp         out  2           response of completed burst, valid while done=1
// AWID/AWADDR/AWLEN/AWSIZE/AWBURST  out  IDWIDTH/32/4/3/2  registered burst fields
// AWLOCK/AWCACHE/AWPROT  out  2/4/3  constant 0
// AWVALID out 1; AWREADY in 1
// WID out IDWIDTH; WDATA out BUSWIDTH; WSTRB out BUSWIDTH/8; WLAST out 1; WVALID out 1; WREADY in 1
// BID in IDWIDTH; BRESP in 2; BVALID in 1; BREADY out 1
// BEHAVIOUR
// Reset: state IDLE; AWVALID, WVALID, WLAST, BREADY, done, busy, data_ready = 0; resp = 00;
//   AW fields, WID, beat counter = 0. Reset mid-burst aborts: all valids low on next edge.
// FSM IDLE -> ADDR -> DATA -> RESP -> IDLE.
// IDLE: start=1 -> latch request, AWVALID=1 next cycle, go ADDR. If start_size exceeds
//   log2(BUSWIDTH/8): no AXI activity, done=1 with resp=10 next cycle, stay IDLE.
// ADDR: AWVALID and AW fields held stable until AWREADY=1; handshake edge -> DATA, beat cnt=0.
// DATA: WVALID = data_valid; data_ready = WREADY; WDATA/WSTRB = wdata_in/wstrb_in (comb);
//   WID = latched id; WLAST = (beat_cnt == latched len). Beat cnt (4-bit) increments on
//   WVALID&WREADY; handshake with WLAST=1 -> RESP. No W beat is issued before AW handshake.
// RESP: BREADY=1; on BVALID: resp = (BID==latched id) ? BRESP : 10; done=1 for one cycle;
//   return IDLE same edge. BVALID while BREADY low is ignored.
// start while busy=1 is ignored (not queued). Latency: start at edge N -> AWVALID at N+1;
//   minimum burst of L+1 beats = 1 (AW) + L+1 (W) + 1 (B) cycles after AWVALID rises.
// data_valid may drop mid-burst; WVALID follows, counter holds. Slave stalls (WREADY=0) hold cnt.
// TESTING
// start addr=0x100,len=0,size=2,INCR,id=1; AWREADY=1, WREADY=1, BVALID/BRESP=00 -> one beat,
//   WLAST=1 on it, done pulse with resp=00, AWADDR=0x100, AWLEN=0.
// len=3, AWREADY held 0 for 3 cycles -> AWVALID and AWADDR stable 3 cycles; 4 W beats, WLAST only on 4th.
// len=7, WREADY toggled 1/0 and data_valid gaps -> exactly 8 handshakes, data order preserved.
// BVALID returns BID=2 for id=1, BRESP=00 -> resp=10 on done; BRESP=11 with matching BID -> resp=11.
// start_size=3 with BUSWIDTH=32 -> no AWVALID, done with resp=10; start while busy -> ignored.
// ARESETn low during DATA beat 2 of 4 -> next cycle all valids 0, busy 0; new start works normally.

Source files
------------

// File: rtl/axi_write_master.sv
// axi_write_master: initiator side of an AXI3 write path.
// A local requester hands over one burst description. The block issues it on AW,
// streams the requester's beats onto W, and then collects the B response.
// Only one burst is in flight at a time.
module axi_write_master #(
  parameter int BUSWIDTH = 32,
  parameter int IDWIDTH  = 2
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  // local request
  input  logic                  start,
  input  logic [31:0]           start_addr,
  input  logic [3:0]            start_len,
  input  logic [2:0]            start_size,
  input  logic [1:0]            start_burst,
  input  logic [IDWIDTH-1:0]    start_id,
  output logic                  busy,
  // local data stream
  input  logic [BUSWIDTH-1:0]   wdata_in,
  input  logic [BUSWIDTH/8-1:0] wstrb_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  // completion
  output logic                  done,
  output logic [1:0]            resp,
  // AW channel
  output logic [IDWIDTH-1:0]    AWID,
  output logic [31:0]           AWADDR,
  output logic [3:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic [1:0]            AWBURST,
  output logic [1:0]            AWLOCK,
  output logic [3:0]            AWCACHE,
  output logic [2:0]            AWPROT,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  // W channel
  output logic [IDWIDTH-1:0]    WID,
  output logic [BUSWIDTH-1:0]   WDATA,
  output logic [BUSWIDTH/8-1:0] WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  // B channel
  input  logic [IDWIDTH-1:0]    BID,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY
);

  localparam int         STRBW    = BUSWIDTH / 8;
  // Largest legal AxSIZE: a beat may not be wider than the data bus.
  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRBW));
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          addr_q,  addr_d;
  logic [3:0]           len_q,   len_d;
  logic [2:0]           size_q,  size_d;
  logic [1:0]           burst_q, burst_d;
  logic [IDWIDTH-1:0]   id_q,    id_d;
  logic [3:0]           cnt_q,   cnt_d;
  logic                 done_q,  done_d;
  logic [1:0]           resp_q,  resp_d;

  logic                 in_data;
  logic                 last_beat;
  logic                 w_hs;

  // A request whose beat is wider than the bus cannot be issued at all.
  function automatic logic size_legal(input logic [2:0] sz);
    return (sz <= MAX_SIZE);
  endfunction

  // A response carrying someone else's ID is reported as a slave error.
  function automatic logic [1:0] resp_check(input logic [IDWIDTH-1:0] bid,
                                            input logic [1:0]         bresp,
                                            input logic [IDWIDTH-1:0] exp_id);
    return (bid == exp_id) ? bresp : RESP_SLVERR;
  endfunction

  assign in_data   = (state_q == S_DATA);
  assign last_beat = (cnt_q == len_q);
  assign w_hs      = WVALID & WREADY;

  // Channel outputs decode from registered state, so AW and B signals are glitch-free.
  assign busy       = (state_q != S_IDLE);
  assign AWVALID    = (state_q == S_ADDR);
  assign AWID       = id_q;
  assign AWADDR     = addr_q;
  assign AWLEN      = len_q;
  assign AWSIZE     = size_q;
  assign AWBURST    = burst_q;
  assign AWLOCK     = 2'b00;
  assign AWCACHE    = 4'b0000;
  assign AWPROT     = 3'b000;

  // W beats pass straight through from the requester; only valid/last are gated.
  assign WID        = id_q;
  assign WDATA      = wdata_in;
  assign WSTRB      = wstrb_in;
  assign WVALID     = in_data & data_valid;
  assign WLAST      = in_data & last_beat;
  assign data_ready = in_data & WREADY;

  assign BREADY     = (state_q == S_RESP);
  assign done       = done_q;
  assign resp       = resp_q;

  // Next-state and register-update logic for the burst sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    resp_d  = resp_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (size_legal(start_size)) begin
            addr_d  = start_addr;
            len_d   = start_len;
            size_d  = start_size;
            burst_d = start_burst;
            id_d    = start_id;
            state_d = S_ADDR;
          end else begin
            // Reject without touching the bus.
            done_d = 1'b1;
            resp_d = RESP_SLVERR;
          end
        end
      end

      S_ADDR: begin
        if (AWREADY) begin
          cnt_d   = 4'd0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (w_hs) begin
          if (last_beat) begin
            state_d = S_RESP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      S_RESP: begin
        if (BVALID) begin
          resp_d  = resp_check(BID, BRESP, id_q);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and burst registers; reset aborts any burst in progress.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      resp_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      resp_q  <= resp_d;
    end
  end

endmodule

// File: tb/tb_axi_write_master.sv
// tb_axi_write_master: directed bench for axi_write_master (BUSWIDTH=32, IDWIDTH=2).
module tb_axi_write_master;

  logic        ACLK;
  logic        ARESETn;
  logic        start;
  logic [31:0] start_addr;
  logic [3:0]  start_len;
  logic [2:0]  start_size;
  logic [1:0]  start_burst;
  logic [1:0]  start_id;
  logic        busy;
  logic [31:0] wdata_in;
  logic [3:0]  wstrb_in;
  logic        data_valid;
  logic        data_ready;
  logic        done;
  logic [1:0]  resp;
  logic [1:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [1:0]  AWLOCK;
  logic [3:0]  AWCACHE;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [1:0]  WID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  axi_write_master #(.BUSWIDTH(32), .IDWIDTH(2)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .start(start), .start_addr(start_addr), .start_len(start_len),
    .start_size(start_size), .start_burst(start_burst), .start_id(start_id),
    .busy(busy),
    .wdata_in(wdata_in), .wstrb_in(wstrb_in), .data_valid(data_valid),
    .data_ready(data_ready),
    .done(done), .resp(resp),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] wq[$];
  logic        lq[$];
  logic [31:0] awq[$];
  logic [31:0] dbase;

  // Record every W and AW handshake seen on the bus.
  always @(posedge ACLK) begin
    if (ARESETn) begin
      if (WVALID && WREADY) begin
        wq.push_back(WDATA);
        lq.push_back(WLAST);
      end
      if (AWVALID && AWREADY) awq.push_back(AWADDR);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [1:0] id);
    @(negedge ACLK);
    wq.delete(); lq.delete(); awq.delete();
    start = 1'b1; start_addr = a; start_len = l; start_size = s;
    start_burst = b; start_id = id;
    @(negedge ACLK);
    start = 1'b0;
    #1;
  endtask

  task automatic run_burst(input int maxcyc, input logic [31:0] wr_pat, input logic [31:0] dv_pat,
                           output bit got, output logic [1:0] r, output int ncyc);
    got = 1'b0; r = 2'b00; ncyc = -1;
    for (int c = 0; c < maxcyc; c++) begin
      @(negedge ACLK);
      WREADY     = wr_pat[c % 32];
      data_valid = dv_pat[c % 32];
      wdata_in   = dbase + 32'(wq.size());
      #1;
      if (done) begin
        got = 1'b1; r = resp; ncyc = c;
        break;
      end
    end
  endtask

  task automatic check_beats(input string tag, input int nexp, input logic [15:0] last_exp);
    logic [15:0] lb;
    lb = '0;
    check({tag, "_nbeats"}, 64'(wq.size()), 64'(nexp));
    foreach (lq[i]) if (i < 16) lb[i] = lq[i];
    check({tag, "_wlast"}, 64'(lb), 64'(last_exp));
    foreach (wq[i]) check($sformatf("%s_data%0d", tag, i), 64'(wq[i]), 64'(dbase + 32'(i)));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got;
    logic [1:0]  r;
    int          ncyc;

    ARESETn = 1'b0; start = 1'b0; start_addr = '0; start_len = '0; start_size = '0;
    start_burst = '0; start_id = '0; wdata_in = '0; wstrb_in = 4'hF; data_valid = 1'b0;
    AWREADY = 1'b0; WREADY = 1'b0; BID = '0; BRESP = '0; BVALID = 1'b0; dbase = '0;

    // ---- reset state
    repeat (3) @(negedge ACLK);
    #1;
    check("rst_awvalid", AWVALID, 1'b0);
    check("rst_wvalid", WVALID, 1'b0);
    check("rst_wlast", WLAST, 1'b0);
    check("rst_bready", BREADY, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data_ready", data_ready, 1'b0);
    check("rst_resp", resp, 2'b00);
    check("rst_awaddr", AWADDR, 32'h0);
    check("rst_wid", WID, 2'b00);
    ARESETn = 1'b1;

    // ---- single-beat burst, everything ready
    AWREADY = 1'b1; WREADY = 1'b1; data_valid = 1'b1; BVALID = 1'b1; BID = 2'd1; BRESP = 2'b00;
    dbase = 32'hA000_0000;
    do_start(32'h100, 4'd0, 3'd2, 2'b01, 2'd1);
    check("t1_awvalid", AWVALID, 1'b1);
    check("t1_awaddr", AWADDR, 32'h100);
    check("t1_awlen", AWLEN, 4'd0);
    check("t1_awsize", AWSIZE, 3'd2);
    check("t1_awburst", AWBURST, 2'b01);
    check("t1_awid", AWID, 2'd1);
    check("t1_awconst", {AWLOCK, AWCACHE, AWPROT}, 9'd0);
    check("t1_busy", busy, 1'b1);
    run_burst(40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, r, ncyc);
    check("t1_done", got, 1'b1);
    check("t1_resp", r, 2'b00);
    check("t1_latency", 64'(ncyc), 64'd2);
    check_beats("t1", 1, 16'h0001);
    check("t1_busy_after", busy, 1'b0);

    // ---- len=3 with AWREADY stalled 3 cycles
    AWREADY = 1'b0; dbase = 32'hB000_0000; wdata_in = dbase;
    do_start(32'h2000, 4'd3, 3'd2, 2'b01, 2'd1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin @(negedge ACLK); #1; end
      check($sformatf("t2_awvalid%0d", k), AWVALID, 1'b1);
      check($sformatf("t2_awaddr%0d", k), AWADDR, 32'h2000);
      check($sformatf("t2_no_early_w%0d", k), WVALID, 1'b0);
    end
    AWREADY = 1'b1;
    run_burst(40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, r, ncyc);
    check("t2_done", got, 1'b1);
    check("t2_latency", 64'(ncyc), 64'd5);
    check_beats("t2", 4, 16'h0008);

    // ---- len=7 with WREADY toggling and data_valid gaps
    dbase = 32'hC000_0000;
    do_start(32'h3000, 4'd7, 3'd2, 2'b01, 2'd1);
    run_burst(60, 32'h5555_5555, 32'hFFFF_3377, got, r, ncyc);
    check("t3_done", got, 1'b1);
    check("t3_resp", r, 2'b00);
    check_beats("t3", 8, 16'h0080);

    // ---- BID mismatch -> SLVERR; matching BID passes BRESP through
    dbase = 32'hD000_0000; BID = 2'd2; BRESP = 2'b00;
    do_start(32'h400, 4'd0, 3'd2, 2'b01, 2'd1);
    run_burst(40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, r, ncyc);
    check("t4a_done", got, 1'b1);
    check("t4a_resp", r, 2'b10);
    BID = 2'd3; BRESP = 2'b11;
    do_start(32'h500, 4'd0, 3'd2, 2'b01, 2'd3);
    run_burst(40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, r, ncyc);
    check("t4b_done", got, 1'b1);
    check("t4b_resp", r, 2'b11);

    // ---- oversize beat rejected without bus activity
    BID = 2'd1; BRESP = 2'b00;
    do_start(32'h40, 4'd0, 3'd3, 2'b01, 2'd1);
    check("t5_done", done, 1'b1);
    check("t5_resp", resp, 2'b10);
    check("t5_awvalid", AWVALID, 1'b0);
    check("t5_busy", busy, 1'b0);
    @(negedge ACLK); #1;
    check("t5_done_pulse", done, 1'b0);
    check("t5_no_aw", 64'(awq.size()), 64'd0);

    // ---- start while busy is ignored
    AWREADY = 1'b0; BID = 2'd2; dbase = 32'hE000_0000;
    do_start(32'h3000, 4'd1, 3'd2, 2'b01, 2'd2);
    @(negedge ACLK);
    start = 1'b1; start_addr = 32'h9999_0000; start_len = 4'd5;
    @(negedge ACLK);
    start = 1'b0;
    #1;
    check("t6_awaddr_kept", AWADDR, 32'h3000);
    check("t6_awlen_kept", AWLEN, 4'd1);
    AWREADY = 1'b1;
    run_burst(40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, r, ncyc);
    check("t6_done", got, 1'b1);
    check("t6_resp", r, 2'b00);
    check_beats("t6", 2, 16'h0002);
    repeat (3) @(negedge ACLK);
    #1;
    check("t6_one_aw", 64'(awq.size()), 64'd1);
    check("t6_idle", busy, 1'b0);

    // ---- reset during beat 2 of 4, then a clean burst
    BID = 2'd1; WREADY = 1'b1; data_valid = 1'b1; dbase = 32'hF000_0000;
    do_start(32'h4000, 4'd3, 3'd2, 2'b01, 2'd1);
    @(negedge ACLK);
    @(negedge ACLK);
    @(negedge ACLK);
    #1;
    check("t7_beats_before_rst", 64'(wq.size()), 64'd2);
    check("t7_wvalid_beat2", WVALID, 1'b1);
    ARESETn = 1'b0;
    @(negedge ACLK); #1;
    check("t7_awvalid", AWVALID, 1'b0);
    check("t7_wvalid", WVALID, 1'b0);
    check("t7_wlast", WLAST, 1'b0);
    check("t7_bready", BREADY, 1'b0);
    check("t7_busy", busy, 1'b0);
    check("t7_data_ready", data_ready, 1'b0);
    ARESETn = 1'b1;
    do_start(32'h5000, 4'd1, 3'd2, 2'b01, 2'd1);
    check("t7_awaddr_new", AWADDR, 32'h5000);
    run_burst(40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, r, ncyc);
    check("t7_done", got, 1'b1);
    check("t7_resp", r, 2'b00);
    check_beats("t7", 2, 16'h0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
